// File: rtl/shift_arb_pkg.sv
// shift_arb_pkg: shift op encodings and output register state for shift_arbiter
package shift_arb_pkg;
   localparam logic [1:0] ALUC_SRA = 2'b00;
   localparam logic [1:0] ALUC_SRL = 2'b10;
   localparam logic [1:0] ALUC_SLL = 2'b01;
   typedef enum logic {EMPTY, FULL} state_e;
endpackage

// File: rtl/shift_arb_rr.sv
// shift_arb_rr: combinational round-robin picker, first set request at or after ptr_i with wrap
module shift_arb_rr #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o
);
   // scan farthest-first so the closest request to ptr_i is the last writer
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (req_i[(int'(ptr_i) + k) % N]) begin
            gnt_o = N'(1) << ((int'(ptr_i) + k) % N);
            idx_o = IW'((int'(ptr_i) + k) % N);
         end
      end
   end
endmodule

// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin shared barrel shifter with a single-entry tagged result register.
// Define SHIFT_ARB_PRIO0_EN to give requester 0 absolute priority over the rotating others.
module shift_arbiter
   import shift_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic [32*NUM_REQ-1:0] req_a,
   input  logic [5*NUM_REQ-1:0]  req_b,
   input  logic [2*NUM_REQ-1:0]  req_aluc,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [ID_W-1:0]       rsp_id,
   output logic [31:0]           rsp_data
);
   state_e             state_q;
   logic [31:0]        rsp_data_q;
   logic [ID_W-1:0]    rsp_id_q;
   logic [ID_W-1:0]    rr_ptr_q;
   logic [ID_W-1:0]    rr_ptr_d;
   logic [NUM_REQ-1:0] rr_req;
   logic [NUM_REQ-1:0] rr_gnt;
   logic [ID_W-1:0]    rr_idx;
   logic [ID_W-1:0]    rr_nxt;
   logic [NUM_REQ-1:0] gnt;
   logic [ID_W-1:0]    gnt_idx;
   logic               slot_free;
   logic               take;
   logic [31:0]        a_arr [NUM_REQ];
   logic [4:0]         b_arr [NUM_REQ];
   logic [1:0]         c_arr [NUM_REQ];
   logic [31:0]        a_sel;
   logic [4:0]         b_sel;
   logic [1:0]         c_sel;
   logic               fill;
   logic               left;
   logic [31:0]        st [6];
   genvar i;
   genvar s;
   generate
      for (i = 0; i < NUM_REQ; i++) begin : g_unpack
         assign a_arr[i] = req_a[32*i +: 32];
         assign b_arr[i] = req_b[5*i +: 5];
         assign c_arr[i] = req_aluc[2*i +: 2];
      end
   endgenerate
   shift_arb_rr #(.N(NUM_REQ), .IW(ID_W)) u_rr (
      .req_i (rr_req),
      .ptr_i (rr_ptr_q),
      .gnt_o (rr_gnt),
      .idx_o (rr_idx)
   );
   assign rr_nxt = (rr_idx == ID_W'(NUM_REQ - 1)) ? '0 : rr_idx + 1'b1;
`ifdef SHIFT_ARB_PRIO0_EN
   // requester 0 bypasses the rotation and leaves the pointer untouched
   assign rr_req   = {req_valid[NUM_REQ-1:1], 1'b0};
   assign gnt      = req_valid[0] ? NUM_REQ'(1) : rr_gnt;
   assign gnt_idx  = req_valid[0] ? '0 : rr_idx;
   assign rr_ptr_d = req_valid[0] ? rr_ptr_q : rr_nxt;
`else
   assign rr_req   = req_valid;
   assign gnt      = rr_gnt;
   assign gnt_idx  = rr_idx;
   assign rr_ptr_d = rr_nxt;
`endif
   assign slot_free = (state_q == EMPTY) || rsp_ready;
   assign req_ready = slot_free ? gnt : '0;
   assign take      = |req_ready;
   assign a_sel = a_arr[gnt_idx];
   assign b_sel = b_arr[gnt_idx];
   assign c_sel = c_arr[gnt_idx];
   assign fill  = (c_sel == ALUC_SRA) && a_sel[31];
   assign left  = c_sel[0];
   assign st[0] = a_sel;
   generate
      for (s = 0; s < 5; s++) begin : g_stage
         localparam int W = 1 << s;
         assign st[s+1] = !b_sel[s] ? st[s] :
                          left      ? {st[s][31-W:0], {W{1'b0}}} :
                                      {{W{fill}}, st[s][31:W]};
      end
   endgenerate
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= EMPTY;
         rsp_data_q <= '0;
         rsp_id_q   <= '0;
         rr_ptr_q   <= '0;
      end else if (take) begin
         state_q    <= FULL;
         rsp_data_q <= st[5];
         rsp_id_q   <= gnt_idx;
         rr_ptr_q   <= rr_ptr_d;
      end else if (state_q == FULL && rsp_ready) begin
         state_q <= EMPTY;
      end
   end
   assign rsp_valid = (state_q == FULL);
   assign rsp_data  = rsp_data_q;
   assign rsp_id    = rsp_id_q;
endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter: per-cycle model comparison plus directed literal checks for shift_arbiter
module tb_shift_arbiter;
   localparam int N = 4;
   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [32*N-1:0] req_a;
   logic [5*N-1:0]  req_b;
   logic [2*N-1:0]  req_aluc;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [1:0]      rsp_id;
   logic [31:0]     rsp_data;
   int n_chk = 0;
   int n_fail = 0;
   bit          m_init = 0;
   bit          m_full;
   logic [31:0] m_data;
   int          m_id;
   int          m_ptr;
   logic [N-1:0] m_g;
   int          m_gi;
   shift_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_aluc  (req_aluc),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data)
   );
   always #5 clk = ~clk;
   function automatic logic [N-1:0] exp_ready(logic [N-1:0] v, bit full, bit rdy, int ptr);
      if (full && !rdy) return '0;
`ifdef SHIFT_ARB_PRIO0_EN
      if (v[0]) return 1;
      for (int k = 0; k < N; k++)
         if ((ptr + k) % N != 0 && v[(ptr + k) % N]) return N'(1) << ((ptr + k) % N);
`else
      for (int k = 0; k < N; k++)
         if (v[(ptr + k) % N]) return N'(1) << ((ptr + k) % N);
`endif
      return '0;
   endfunction
   function automatic logic [31:0] shift_ref(logic [31:0] a, logic [4:0] b, logic [1:0] c);
      if (c == 2'b00) return 32'($signed(a) >>> b);
      if (c == 2'b10) return a >> b;
      return a << b;
   endfunction
   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask
   // reference model: follows the grant/drain rules at every rising edge
   always @(posedge clk) begin
      if (rst) begin
         m_full = 0;
         m_data = '0;
         m_id   = 0;
         m_ptr  = 0;
         m_init = 1;
      end else begin
         m_g = exp_ready(req_valid, m_full, rsp_ready, m_ptr);
         if (m_g != '0) begin
            for (int j = 0; j < N; j++) if (m_g[j]) m_gi = j;
            m_data = shift_ref(req_a[32*m_gi +: 32], req_b[5*m_gi +: 5], req_aluc[2*m_gi +: 2]);
            m_id   = m_gi;
            m_full = 1;
`ifdef SHIFT_ARB_PRIO0_EN
            if (m_gi != 0) m_ptr = (m_gi + 1) % N;
`else
            m_ptr = (m_gi + 1) % N;
`endif
         end else if (rsp_ready) begin
            m_full = 0;
         end
      end
   end
   always @(negedge clk) begin
      if (m_init) begin
         chk("model req_ready", 32'(req_ready), 32'(exp_ready(req_valid, m_full, rsp_ready, m_ptr)));
         chk("model rsp_valid", 32'(rsp_valid), 32'(m_full));
         chk("model rsp_data", rsp_data, m_data);
         chk("model rsp_id", 32'(rsp_id), 32'(m_id));
      end
   end
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   task automatic set_req(int i, logic [31:0] a, logic [4:0] b, logic [1:0] c);
      req_a[32*i +: 32] = a;
      req_b[5*i +: 5]   = b;
      req_aluc[2*i +: 2] = c;
   endtask
   task automatic single(string nm, int id, logic [31:0] a, logic [4:0] b, logic [1:0] c, logic [31:0] exp);
      set_req(id, a, b, c);
      req_valid = N'(1) << id;
      rsp_ready = 1'b1;
      cyc();
      req_valid = '0;
      chk({nm, " data"}, rsp_data, exp);
      chk({nm, " id"}, 32'(rsp_id), 32'(id));
      chk({nm, " valid"}, 32'(rsp_valid), 32'd1);
   endtask
   initial begin
      rst = 1'b1;
      req_valid = '0;
      rsp_ready = 1'b0;
      req_a = '0;
      req_b = '0;
      req_aluc = '0;
      repeat (3) cyc();
      chk("reset valid", 32'(rsp_valid), 32'd0);
      chk("reset data", rsp_data, 32'd0);
      chk("reset id", 32'(rsp_id), 32'd0);
      rst = 1'b0;
      single("sra", 0, 32'h8000_0000, 5'd4, 2'b00, 32'hF800_0000);
      single("srl", 1, 32'h8000_0000, 5'd31, 2'b10, 32'h0000_0001);
      single("sll01", 2, 32'h0000_0001, 5'd31, 2'b01, 32'h8000_0000);
      single("sll11", 3, 32'h0000_0001, 5'd31, 2'b11, 32'h8000_0000);
      single("sra0", 0, 32'h1234_5678, 5'd0, 2'b00, 32'h1234_5678);
      single("srl0", 0, 32'h1234_5678, 5'd0, 2'b10, 32'h1234_5678);
      single("sll0", 0, 32'h1234_5678, 5'd0, 2'b01, 32'h1234_5678);
`ifndef SHIFT_ARB_PRIO0_EN
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      for (int i = 0; i < N; i++) set_req(i, 32'h100 * (i + 1), 5'(i), 2'b01);
      req_valid = '1;
      rsp_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         cyc();
         chk("rr id seq", 32'(rsp_id), 32'(k % N));
      end
      chk("rr data id1", rsp_data, 32'h0000_0400);
      rsp_ready = 1'b0;
      #1;
      chk("bp ready", 32'(req_ready), 32'd0);
      repeat (5) begin
         cyc();
         chk("bp ready", 32'(req_ready), 32'd0);
         chk("bp data", rsp_data, 32'h0000_0400);
         chk("bp id", 32'(rsp_id), 32'd1);
      end
      rsp_ready = 1'b1;
      #1;
      chk("bp release ready", 32'(req_ready), 32'b0100);
      cyc();
      chk("bp release id", 32'(rsp_id), 32'd2);
      chk("bp release data", rsp_data, 32'h0000_0C00);
      req_valid = 4'b0010;
      cyc();
      chk("ptr setup id", 32'(rsp_id), 32'd1);
      req_valid = 4'b1010;
      #1;
      chk("pair ready first", 32'(req_ready), 32'b1000);
      cyc();
      chk("pair id first", 32'(rsp_id), 32'd3);
      chk("pair ready second", 32'(req_ready), 32'b0010);
      cyc();
      chk("pair id second", 32'(rsp_id), 32'd1);
`endif
      for (int i = 0; i < N; i++) set_req(i, 32'h100 * (i + 1), 5'(i), 2'b01);
      req_valid = '1;
      rsp_ready = 1'b0;
      cyc();
      rst = 1'b1;
      rsp_ready = 1'b1;
      cyc();
      chk("rst full valid", 32'(rsp_valid), 32'd0);
      chk("rst full data", rsp_data, 32'd0);
      chk("rst full id", 32'(rsp_id), 32'd0);
      rst = 1'b0;
      cyc();
      chk("post rst id", 32'(rsp_id), 32'd0);
      chk("post rst data", rsp_data, 32'h0000_0100);
`ifdef SHIFT_ARB_PRIO0_EN
      repeat (3) begin
         cyc();
         chk("prio0 id", 32'(rsp_id), 32'd0);
      end
      req_valid = 4'b1110;
      for (int k = 1; k < N; k++) begin
         cyc();
         chk("prio0 rotate id", 32'(rsp_id), 32'(k));
      end
`endif
      req_valid = '0;
      repeat (2) cyc();
      chk("drain valid", 32'(rsp_valid), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
